sram_bank_arbiter: RTL and testbench
====================================

# sram_bank_arbiter

Two-requester arbiter that shares one generic SRAM bank (the single-port bank behind the AXI4-to-memory bridge) between the bridge's bank port and a second on-chip master such as a boot loader or DMA. It round-robins single-cycle accesses and supports locked access sequences with a bounded hold time. It also tracks the fixed read latency so that each read word returns only to the requester that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 12, bank word-address width
- DATA_WIDTH, 32, bank data width; multiple of 8
- READ_LATENCY, 2, cycles from accepted read to valid i_mem_rdata; range 1..4
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release; range 2..255

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  2  access request per requester; held until granted
- i_lock  in  2  requester asks to keep ownership after this access
- i_we  in  2  write enable per requester
- i_be  in  2×DATA_WIDTH/8  byte enables per requester
- i_addr  in  2×ADDR_WIDTH  address per requester
- i_wdata  in  2×DATA_WIDTH  write data per requester
- o_gnt  out  2  access accepted this cycle; one-hot or zero
- o_rvalid  out  2  read data valid for requester
- o_rdata  out  DATA_WIDTH  read data, shared by both requesters
- o_lock_err  out  1  one-cycle pulse on a forced lock release
- o_mem_ce, o_mem_we  out  1 each  bank chip enable and write enable
- o_mem_be  out  DATA_WIDTH/8  bank byte enables
- o_mem_addr  out  ADDR_WIDTH  bank address
- o_mem_wdata  out  DATA_WIDTH  bank write data
- i_mem_rdata  in  DATA_WIDTH  bank read data

## Operation
- FSM states: ST_RR, ST_LOCK0, ST_LOCK1.
- **ST_RR:**
  - A single requester is granted immediately.
  - If both request, the requester with priority pointer prio (1 bit) is granted.
  - After any grant to requester r, prio becomes ~r.
- **Entering lock:** a grant to r with i_lock[r]=1 moves the FSM to ST_LOCKr and clears lock_cnt.
- **ST_LOCKr:**
  - Only r may be granted; the other requester waits, and its i_req stays asserted.
  - A grant to r with i_lock[r]=0 returns the FSM to ST_RR and sets prio=~r.
  - A grant to r with i_lock[r]=1 keeps the lock.
  - lock_cnt increments every cycle spent in the state.
- **Forced release:** when lock_cnt reaches LOCK_MAX-1 without a release, the FSM moves to ST_RR, sets prio=~r and pulses o_lock_err. The release cycle itself grants normally in ST_RR priority.
- **Memory port:**
  - o_mem_ce = |o_gnt.
  - o_mem_we/be/addr/wdata are muxed combinationally from the granted requester; they are zero when there is no grant.
  - Writes complete on the grant cycle and produce no response.
- **Read return:**
  - A READ_LATENCY-deep shift register of {valid, id} is loaded on every grant with we=0.
  - o_rvalid[id] = stage[READ_LATENCY-1].valid.
  - o_rdata = i_mem_rdata, passed through unregistered.
  - Back-to-back reads from either requester are fully pipelined, one per cycle.
- **Reset:** FSM=ST_RR, prio=0, lock_cnt=0, and the return pipe is cleared (in-flight reads are dropped).
  - Output values while i_rst=1: o_gnt=0, o_rvalid=0, o_lock_err=0, all o_mem_* = 0.
  - o_rdata follows i_mem_rdata.

## Timing
- o_gnt is combinational from i_req, FSM state and prio: zero-cycle grant.
- o_mem_* are combinational in the grant cycle.
- Read data: a read granted in cycle N gives o_rvalid[id]=1 in cycle N+READ_LATENCY, for exactly one cycle.
- A write granted in cycle N+1 does not disturb the return of the read granted in cycle N.
- Requester obligation: hold req/we/be/addr/wdata stable until o_gnt. An access is consumed on every cycle with o_gnt=1.
- Simultaneous release and a new request from the other requester: in the release cycle only the owner is granted; the other requester is granted in the next cycle.
- o_lock_err is registered and asserts in the cycle the FSM enters ST_RR through forced release.

## Structure
- Package sram_arb_pkg holds:
  - the state enum: st_e {ST_RR, ST_LOCK0, ST_LOCK1};
  - the return-pipe entry struct: {logic valid; logic id;}.
- Sub-module sram_arb_rdpipe, parameterised by READ_LATENCY, implements the {valid, id} shift register with synchronous clear.
- The top level holds the FSM, prio, lock_cnt and the request mux.

## Test plan
- Both requesters issue continuous reads, addr0=0x010 and addr1=0x020 → grants alternate 0,1,0,1. o_rvalid alternates with a two-cycle lag, and o_rdata matches memory contents.
- Requester 1 holds i_lock=1 for 3 writes while requester 0 requests → o_gnt[0]=0 during the lock. Requester 0 is granted the cycle after requester 1's access with lock=0.
- Requester 0 locks, then drops i_req with i_lock left high → forced release after 16 cycles, o_lock_err pulses once, and requester 1 is then granted.
- Write 0xDEADBEEF with be=4'b0011 to 0x005, then read 0x005 → o_mem_be=0011 on the write. The read returns the old upper bytes over 0xBEEF.
- Read granted, then i_rst asserted at N+1 → no o_rvalid at N+2. All outputs are zero during reset, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM bank arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_RR,
    ST_LOCK0,
    ST_LOCK1
  } st_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_entry_t;

endpackage

// File: rtl/sram_arb_rdpipe.sv
// Fixed-latency {valid, id} shift register that steers read data back to its issuer.
module sram_arb_rdpipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic      clk,
  input  logic      clr,
  input  rd_entry_t load,
  output rd_entry_t head
);

  rd_entry_t stage [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) stage[i] <= '0;
    end else begin
      stage[0] <= load;
      for (int i = 1; i < int'(READ_LATENCY); i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[READ_LATENCY-1];

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between two requesters,
// with bounded locked sequences and read-return steering.
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_req,
  input  logic [1:0]                i_lock,
  input  logic [1:0]                i_we,
  input  logic [2*DATA_WIDTH/8-1:0] i_be,
  input  logic [2*ADDR_WIDTH-1:0]   i_addr,
  input  logic [2*DATA_WIDTH-1:0]   i_wdata,
  output logic [1:0]                o_gnt,
  output logic [1:0]                o_rvalid,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_lock_err,
  output logic                      o_mem_ce,
  output logic                      o_mem_we,
  output logic [DATA_WIDTH/8-1:0]   o_mem_be,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 8;

  st_e              state, state_n;
  logic             prio, prio_n;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_n;
  logic             lock_err, lock_err_n;
  logic [1:0]       gnt;
  logic             gid;
  logic             owner;
  logic             owner_release;
  rd_entry_t        rd_load, rd_head;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_RR;
      prio     <= 1'b0;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_n;
      prio     <= prio_n;
      lock_cnt <= lock_cnt_n;
      lock_err <= lock_err_n;
    end
  end

  // Grant selection and next-state
  always_comb begin
    gnt           = '0;
    state_n       = state;
    prio_n        = prio;
    lock_cnt_n    = lock_cnt;
    lock_err_n    = 1'b0;
    owner         = (state == ST_LOCK1);
    owner_release = 1'b0;
    unique case (state)
      ST_RR: begin
        if (&i_req) gnt[prio] = 1'b1;
        else        gnt       = i_req;
        if (|gnt) begin
          prio_n = ~gnt[1];
          if (i_lock[gnt[1]]) begin
            state_n    = gnt[1] ? ST_LOCK1 : ST_LOCK0;
            lock_cnt_n = '0;
          end
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        gnt[owner]    = i_req[owner];
        owner_release = i_req[owner] & ~i_lock[owner];
        lock_cnt_n    = lock_cnt + CNT_W'(1);
        // An owner-initiated release wins over the hold-time limit.
        if (owner_release || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state_n    = ST_RR;
          prio_n     = ~owner;
          lock_err_n = ~owner_release;
        end
      end
      default: state_n = ST_RR;
    endcase
    if (i_rst) gnt = '0;
  end

  assign gid         = gnt[1];
  assign o_gnt       = gnt;
  assign o_mem_ce    = |gnt;
  assign o_mem_we    = o_mem_ce & i_we[gid];
  assign o_mem_be    = !o_mem_ce ? '0 : gid ? i_be[2*BE_W-1:BE_W] : i_be[BE_W-1:0];
  assign o_mem_addr  = !o_mem_ce ? '0 :
                       gid ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
  assign o_mem_wdata = !o_mem_ce ? '0 :
                       gid ? i_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_wdata[DATA_WIDTH-1:0];

  assign rd_load = '{valid: o_mem_ce & ~o_mem_we, id: gid};

  sram_arb_rdpipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rdpipe (
    .clk  (i_clk),
    .clr  (i_rst),
    .load (rd_load),
    .head (rd_head)
  );

  assign o_rvalid   = (rd_head.valid && !i_rst) ? (rd_head.id ? 2'b10 : 2'b01) : 2'b00;
  assign o_rdata    = i_mem_rdata;
  assign o_lock_err = lock_err & ~i_rst;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed plus randomized bench for sram_bank_arbiter against a transaction-level model.
module tb_sram_bank_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned RL = 2;
  localparam int unsigned LM = 16;

  typedef struct {
    bit            lock;
    bit            we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req, lock, we;
  logic [2*BW-1:0] be;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            lock_err, mem_ce, mem_we;
  logic [BW-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  sram_bank_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LOCK_MAX(LM)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock), .i_we(we), .i_be(be),
    .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_lock_err(lock_err), .o_mem_ce(mem_ce), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Bank behaviour: byte-masked write on the access edge, read data RL cycles later.
  logic [DW-1:0] bank [4096];
  logic [DW-1:0] bpipe [RL];
  bit            loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) bank[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < int'(BW); b++)
        if (mem_be[b]) bank[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    bpipe[0] <= (mem_ce && !mem_we) ? bank[mem_addr] : '0;
    for (int i = 1; i < int'(RL); i++) bpipe[i] <= bpipe[i-1];
  end
  assign mem_rdata = bpipe[RL-1];

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  acc_t          q0[$], q1[$];
  bit   [1:0]    idle_lk;
  int            owner = -1;
  bit            turn;
  int            held;
  bit            err_pend;
  rd_t           rq[$];
  logic [DW-1:0] exp_mem [4096];

  function automatic int qsize(int r);
    return (r == 0) ? q0.size() : q1.size();
  endfunction

  function automatic acc_t qfront(int r);
    acc_t a;
    if (r == 0) a = q0[0];
    else        a = q1[0];
    return a;
  endfunction

  task automatic qpush(int r, acc_t a);
    if (r == 0) q0.push_back(a);
    else        q1.push_back(a);
  endtask

  task automatic qpop(int r);
    if (r == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  function automatic acc_t mk(bit lk, bit w, logic [BW-1:0] b, logic [AW-1:0] ad, logic [DW-1:0] d);
    acc_t a;
    a.lock = lk; a.we = w; a.be = b; a.addr = ad; a.wdata = d;
    return a;
  endfunction

  function automatic acc_t rand_acc();
    return mk($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), BW'($urandom),
              AW'($urandom_range(0, 63)), $urandom);
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    acc_t a;
    for (int r = 0; r < 2; r++) begin
      if (qsize(r) > 0) begin
        a = qfront(r);
        req[r] = 1'b1;
        lock[r] = a.lock;
      end else begin
        a = mk(1'b0, 1'($urandom), BW'($urandom), AW'($urandom), $urandom);
        req[r] = 1'b0;
        lock[r] = idle_lk[r];
      end
      we[r]            = a.we;
      be[r*BW +: BW]   = a.be;
      addr[r*AW +: AW] = a.addr;
      wdata[r*DW +: DW] = a.wdata;
    end
  endtask

  // One clock: drive, predict, compare, then advance the model.
  task automatic run_cycle();
    logic [1:0]    eg, ev;
    logic [DW-1:0] ed;
    int            g;
    bit            have;
    acc_t          a;
    rd_t           e;
    drive();
    @(negedge clk);
    eg = '0;
    if (!rst) begin
      if (owner >= 0) begin
        if (qsize(owner) > 0) eg[owner] = 1'b1;
      end else if (qsize(0) > 0 && qsize(1) > 0) begin
        eg[turn] = 1'b1;
      end else begin
        eg[0] = qsize(0) > 0;
        eg[1] = qsize(1) > 0;
      end
    end
    g    = eg[1] ? 1 : 0;
    have = |eg;
    a    = have ? qfront(g) : mk(1'b0, 1'b0, '0, '0, '0);
    ev   = '0;
    ed   = '0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      ev[rq[0].id] = 1'b1;
      ed = rq[0].data;
    end
    check("gnt",       DW'(gnt),       DW'(eg));
    check("mem_ce",    DW'(mem_ce),    DW'(have));
    check("mem_we",    DW'(mem_we),    DW'(have && a.we));
    check("mem_be",    DW'(mem_be),    DW'(a.be));
    check("mem_addr",  DW'(mem_addr),  DW'(a.addr));
    check("mem_wdata", mem_wdata,      a.wdata);
    check("rvalid",    DW'(rvalid),    DW'(ev));
    check("lock_err",  DW'(lock_err),  DW'(!rst && err_pend));
    if (ev != 2'b00) check("rdata", rdata, ed);
    if (rst)         check("rdata_rst", rdata, mem_rdata);

    if (rst) begin
      owner = -1; turn = 1'b0; held = 0; err_pend = 1'b0;
      rq.delete();
    end else begin
      if (ev != 2'b00) void'(rq.pop_front());
      err_pend = 1'b0;
      if (have) begin
        if (!a.we) begin
          e.due = cyc + int'(RL); e.id = g; e.data = exp_mem[a.addr];
          rq.push_back(e);
        end else begin
          for (int b = 0; b < int'(BW); b++)
            if (a.be[b]) exp_mem[a.addr][8*b +: 8] = a.wdata[8*b +: 8];
        end
        qpop(g);
      end
      if (owner < 0) begin
        if (have) begin
          turn = (g == 0);
          if (a.lock) begin owner = g; held = 0; end
        end
      end else begin
        held++;
        if (have && !a.lock) begin
          turn = (owner == 0); owner = -1;
        end else if (held == int'(LM)) begin
          turn = (owner == 0); owner = -1; err_pend = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_val(i);
    idle_lk = 2'b00;
    rst = 1'b1;
    // Pending request during reset must not be granted until reset drops.
    qpush(0, mk(1'b0, 1'b0, '0, 12'h001, '0));
    run(3);
    rst = 1'b0;
    run(3);

    // Continuous reads from both requesters alternate.
    for (int i = 0; i < 4; i++) begin
      qpush(0, mk(1'b0, 1'b0, 4'hF, 12'h010, '0));
      qpush(1, mk(1'b0, 1'b0, 4'hF, 12'h020, '0));
    end
    run(12);

    // Requester 1 holds a lock across writes while requester 0 waits.
    for (int i = 0; i < 3; i++) qpush(1, mk(1'b1, 1'b1, 4'hF, AW'(12'h030 + i), $urandom));
    qpush(1, mk(1'b0, 1'b1, 4'hF, 12'h033, $urandom));
    run(1);
    qpush(0, mk(1'b0, 1'b0, 4'hF, 12'h030, '0));
    run(8);

    // Requester 0 locks and goes idle with lock high: forced release.
    idle_lk[0] = 1'b1;
    qpush(0, mk(1'b1, 1'b0, 4'hF, 12'h011, '0));
    run(1);
    qpush(1, mk(1'b0, 1'b0, 4'hF, 12'h021, '0));
    run(20);
    idle_lk[0] = 1'b0;

    // Partial-byte write then read-back of the merged word.
    qpush(0, mk(1'b0, 1'b1, 4'b0011, 12'h005, 32'hDEAD_BEEF));
    qpush(0, mk(1'b0, 1'b0, 4'hF, 12'h005, '0));
    run(5);

    // Reset one cycle after a read drops its return; first grant then goes to 0.
    qpush(0, mk(1'b0, 1'b0, 4'hF, 12'h006, '0));
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(1);
    qpush(0, mk(1'b0, 1'b0, 4'hF, 12'h007, '0));
    qpush(1, mk(1'b0, 1'b0, 4'hF, 12'h008, '0));
    run(5);

    // Randomized traffic with occasional locks, idle-lock and resets.
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (qsize(r) == 0 && $urandom_range(0, 3) != 0) qpush(r, rand_acc());
        idle_lk[r] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      run_cycle();
    end
    rst = 1'b0;
    q0.delete();
    q1.delete();
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
